// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Instruction-driven address sequencer for a multi-channel MAC datapath.
//   For each channel in a frame, it fetches instructions from the program
//   ROM starting at pc=0. Each instruction optionally writes the new sample
//   into a circular buffer (LOAD). It then walks every slot of that buffer
//   against a coefficient table (MAC) and writes the result register back
//   (STORE). Channels are processed one after another after each sample_vld.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   en                    run enable; low freezes all state and zeroes strobes
//   sample_vld            start of a new frame, looked at only in IDLE
//   instr_word            {lstg_f,upse_f,vec_id,result_reg,error_reg,
//                          data_uptr,data_lptr,coef_ptr}, valid the cycle after fetch
//   fetch, pc             instruction request and program counter
//   ch                    channel currently being processed
//   en_ram_pa, wr_ram_pa  data RAM port enable / write strobe
//   en_ram_pb, wr_ram_pb  coefficient RAM port enable / write strobe (never writes)
//   data_addr             {ch, local data address}
//   coef_addr             coefficient address
//   ar1, ar2, ard, rw     regfile read/read/write addresses and write strobe
//   done                  one-cycle pulse when the last channel of a frame completes
//   err                   sticky error (bad buffer bounds or program overrun)
//
// All state and addresses come straight from registers through a state-decode
// mux. The strobes are additionally gated by en, so a stalled cycle never
// issues a RAM or regfile access.

module mac_sequencer #(
    parameter int VEC_ID_WIDTH       = 3,
    parameter int REGFILE_ADDR_WIDTH = 4,
    parameter int DATA_ADDR_WIDTH    = 6,
    parameter int INSTR_ADDR_WIDTH   = 5,
    parameter int CHANNELS           = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int INSTR_W = 2 + VEC_ID_WIDTH + 2*REGFILE_ADDR_WIDTH + 3*DATA_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            sample_vld,
    input  logic [INSTR_W-1:0]              instr_word,
    output logic                            fetch,
    output logic [INSTR_ADDR_WIDTH-1:0]     pc,
    output logic [CH_W-1:0]                 ch,
    output logic                            en_ram_pa,
    output logic                            en_ram_pb,
    output logic                            wr_ram_pa,
    output logic                            wr_ram_pb,
    output logic [CH_W+DATA_ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_ADDR_WIDTH-1:0]      coef_addr,
    output logic [REGFILE_ADDR_WIDTH-1:0]   ar1,
    output logic [REGFILE_ADDR_WIDTH-1:0]   ar2,
    output logic [REGFILE_ADDR_WIDTH-1:0]   ard,
    output logic                            rw,
    output logic                            done,
    output logic                            err
);

    localparam int NVEC    = 2**VEC_ID_WIDTH;
    localparam int HEAD_CH = 2**CH_W;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    typedef struct packed {
        logic                          lstg;
        logic                          upse;
        logic [VEC_ID_WIDTH-1:0]       vid;
        logic [REGFILE_ADDR_WIDTH-1:0] res;
        logic [REGFILE_ADDR_WIDTH-1:0] erg;
        logic [DATA_ADDR_WIDTH-1:0]    uptr;
        logic [DATA_ADDR_WIDTH-1:0]    lptr;
        logic [DATA_ADDR_WIDTH-1:0]    coef;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_LOAD, S_MAC, S_STORE, S_NEXTCH
    } state_t;

    state_t state, state_nxt;

    instr_t iw;
    assign iw = instr_t'(instr_word);

    // Latched instruction fields (upse_f is only needed at decode time).
    logic                          lstg_q;
    logic [VEC_ID_WIDTH-1:0]       vid_q;
    logic [REGFILE_ADDR_WIDTH-1:0] res_q;
    logic [REGFILE_ADDR_WIDTH-1:0] erg_q;
    logic [DATA_ADDR_WIDTH-1:0]    uptr_q;
    logic [DATA_ADDR_WIDTH-1:0]    lptr_q;
    logic [DATA_ADDR_WIDTH-1:0]    coef_q;

    logic [INSTR_ADDR_WIDTH-1:0]   pc_q;
    logic [CH_W-1:0]               ch_q;
    logic                          err_q;
    logic [DATA_ADDR_WIDTH-1:0]    ptr_q;   // current data slot (h, then h+k wrapped)
    logic [DATA_ADDR_WIDTH-1:0]    k_q;     // MAC tap index

    // Circular buffer head pointers, one per channel per vector id.
    logic [DATA_ADDR_WIDTH-1:0]    head [HEAD_CH][NVEC];

    // Decode-time values, taken from the live instruction word.
    logic [DATA_ADDR_WIDTH-1:0]    head_rd;
    logic [DATA_ADDR_WIDTH-1:0]    h_dec;
    logic                          range_bad;
    logic [DATA_ADDR_WIDTH-1:0]    span;

    assign head_rd   = head[ch_q][iw.vid];
    // A head outside the current window (e.g. after reset or a program
    // change) restarts at the top of the window.
    assign h_dec     = ((head_rd < iw.lptr) || (head_rd > iw.uptr)) ? iw.uptr : head_rd;
    assign range_bad = (iw.uptr < iw.lptr);
    // Last tap index is L-1 = uptr-lptr, which always fits in the pointer width.
    assign span      = uptr_q - lptr_q;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (sample_vld) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (range_bad)    state_nxt = S_STORE;
                else if (iw.upse) state_nxt = S_LOAD;
                else              state_nxt = S_MAC;
            end
            S_LOAD:   state_nxt = S_MAC;
            S_MAC:    if (k_q == span) state_nxt = S_STORE;
            S_STORE: begin
                if (lstg_q || (pc_q == '1)) state_nxt = S_NEXTCH;
                else                        state_nxt = S_FETCH;
            end
            S_NEXTCH: state_nxt = (ch_q == LAST_CH) ? S_IDLE : S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
        if (!en) state_nxt = state;
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            ch_q   <= '0;
            err_q  <= 1'b0;
            lstg_q <= 1'b0;
            vid_q  <= '0;
            res_q  <= '0;
            erg_q  <= '0;
            uptr_q <= '0;
            lptr_q <= '0;
            coef_q <= '0;
            ptr_q  <= '0;
            k_q    <= '0;
            for (int c = 0; c < HEAD_CH; c++)
                for (int v = 0; v < NVEC; v++)
                    head[c][v] <= '0;
        end else if (en) begin
            case (state)
                S_DECODE: begin
                    lstg_q <= iw.lstg;
                    vid_q  <= iw.vid;
                    res_q  <= iw.res;
                    erg_q  <= iw.erg;
                    uptr_q <= iw.uptr;
                    lptr_q <= iw.lptr;
                    coef_q <= iw.coef;
                    ptr_q  <= h_dec;
                    k_q    <= '0;
                    if (range_bad) err_q <= 1'b1;
                end
                S_LOAD: begin
                    // The new sample goes into slot h; the head moves one slot
                    // down for the next frame. MAC still starts at h.
                    head[ch_q][vid_q] <= (ptr_q == lptr_q) ? uptr_q : ptr_q - 1'b1;
                end
                S_MAC: begin
                    k_q   <= k_q + 1'b1;
                    ptr_q <= (ptr_q == uptr_q) ? lptr_q : ptr_q + 1'b1;
                end
                S_STORE: begin
                    if (lstg_q) begin
                        pc_q <= '0;
                    end else if (pc_q == '1) begin
                        // Program ran off the end of the ROM without a last-stage flag.
                        err_q <= 1'b1;
                        pc_q  <= '0;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                S_NEXTCH: ch_q <= (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        fetch     = 1'b0;
        en_ram_pa = 1'b0;
        en_ram_pb = 1'b0;
        wr_ram_pa = 1'b0;
        rw        = 1'b0;
        done      = 1'b0;
        data_addr = '0;
        coef_addr = '0;
        ar1       = '0;
        ar2       = '0;
        ard       = '0;
        case (state)
            S_FETCH: fetch = en;
            S_LOAD: begin
                en_ram_pa = en;
                wr_ram_pa = en;
                data_addr = {ch_q, ptr_q};
            end
            S_MAC: begin
                en_ram_pa = en;
                en_ram_pb = en;
                data_addr = {ch_q, ptr_q};
                coef_addr = coef_q + k_q;
                ar1       = res_q;
                ar2       = erg_q;
            end
            S_STORE: begin
                rw  = en;
                ar1 = res_q;
                ar2 = erg_q;
                ard = res_q;
            end
            S_NEXTCH: done = en && (ch_q == LAST_CH);
            default: ;
        endcase
    end

    assign wr_ram_pb = 1'b0;
    assign pc        = pc_q;
    assign ch        = ch_q;
    assign err       = err_q;

endmodule
